// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART receive path.
`timescale 1ns/1ps

package uart_pkg;

  // Receiver sequencing states; encoding is kept stable for existing users.
  typedef enum logic [1:0] {
    RxIdle  = 2'd0,
    RxStart = 2'd1,
    RxData  = 2'd2,
    RxStop  = 2'd3
  } rx_state_e;

  // Default oversampling ratio (i_tick pulses per bit period).
  localparam int unsigned DefOverSample = 8;

  // Default number of data bits per frame.
  localparam int unsigned DefDataBits = 8;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line.
// Both stages reset high so a line at idle does not look like a start edge.
`timescale 1ns/1ps

module uart_rx_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic meta_q;
  logic sync_q;

  // Shift the raw line through two stages to settle metastability.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= i_d;
      sync_q <= meta_q;
    end
  end

  assign o_q = sync_q;

endmodule

// File: rtl/uart_rx_sequencer.sv
// UART receive sequencer: detects a start edge, samples the start bit at its
// centre, shifts in DataBits data bits LSB-first, checks the stop bit and
// hands the byte to a ready/valid consumer with overrun and framing flags.
`timescale 1ns/1ps

module uart_rx_sequencer
  import uart_pkg::*;
#(
  parameter int unsigned OverSample = DefOverSample,
  parameter int unsigned DataBits   = DefDataBits
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_en,
  input  logic                i_tick,
  input  logic                i_rx,
  input  logic                i_ready,
  output logic                o_presc_en,
  output logic [DataBits-1:0] o_data,
  output logic                o_valid,
  output logic                o_frame_err,
  output logic                o_overrun,
  output logic                o_busy
);

  localparam int unsigned TickW = $clog2(OverSample) + 1;
  localparam int unsigned BitW  = $clog2(DataBits) + 1;

  localparam logic [1:0] StIdle  = RxIdle;
  localparam logic [1:0] StStart = RxStart;
  localparam logic [1:0] StData  = RxData;
  localparam logic [1:0] StStop  = RxStop;

  localparam logic [TickW-1:0] TickHalf = TickW'(OverSample / 2);
  localparam logic [TickW-1:0] TickFull = TickW'(OverSample);
  localparam logic [BitW-1:0]  BitLast  = BitW'(DataBits);

  logic                rx_s;
  logic                rx_prev_q;
  logic                rx_fall;

  logic [1:0]          state_q,    state_d;
  logic [TickW-1:0]    tick_cnt_q, tick_cnt_d;
  logic [TickW-1:0]    tick_nxt;
  logic [BitW-1:0]     bit_cnt_q,  bit_cnt_d;
  logic [BitW-1:0]     bit_nxt;
  logic [DataBits-1:0] shreg_q,    shreg_d;

  logic [DataBits-1:0] data_q,     data_d;
  logic                valid_q,    valid_d;
  logic                ferr_q,     ferr_d;
  logic                ovr_q,      ovr_d;

  logic                frame_good;
  logic                frame_bad;
  logic                handshake;

  uart_rx_sync u_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_rx),
    .o_q     (rx_s)
  );

  // Remember the previous synchronized level for falling-edge detection.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_prev_q <= 1'b1;
    end else begin
      rx_prev_q <= rx_s;
    end
  end

  assign rx_fall  = rx_prev_q & ~rx_s;
  assign tick_nxt = tick_cnt_q + TickW'(1);
  assign bit_nxt  = bit_cnt_q + BitW'(1);

  // Frame sequencing: state, tick/bit counters and the data shift register.
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    frame_good = 1'b0;
    frame_bad  = 1'b0;

    case (state_q)
      StIdle: begin
        // Ticks are ignored here; only a start edge moves us on.
        if (i_en && rx_fall) begin
          state_d    = StStart;
          tick_cnt_d = '0;
          bit_cnt_d  = '0;
        end
      end

      StStart: begin
        if (i_tick) begin
          tick_cnt_d = tick_nxt;
          if (tick_nxt == TickHalf) begin
            // Centre of the start bit: a high line means it was a glitch.
            tick_cnt_d = '0;
            state_d    = rx_s ? StIdle : StData;
          end
        end
      end

      StData: begin
        if (i_tick) begin
          tick_cnt_d = tick_nxt;
          if (tick_nxt == TickFull) begin
            tick_cnt_d = '0;
            shreg_d    = {rx_s, shreg_q[DataBits-1:1]};
            bit_cnt_d  = bit_nxt;
            if (bit_nxt == BitLast) begin
              bit_cnt_d = '0;
              state_d   = StStop;
            end
          end
        end
      end

      StStop: begin
        if (i_tick) begin
          tick_cnt_d = tick_nxt;
          if (tick_nxt == TickFull) begin
            tick_cnt_d = '0;
            state_d    = StIdle;
            frame_good = rx_s;
            frame_bad  = ~rx_s;
          end
        end
      end

      default: begin
        state_d    = StIdle;
        tick_cnt_d = '0;
        bit_cnt_d  = '0;
      end
    endcase

    // Disabling mid-frame abandons the frame silently.
    if (!i_en && (state_q != StIdle)) begin
      state_d    = StIdle;
      tick_cnt_d = '0;
      bit_cnt_d  = '0;
      frame_good = 1'b0;
      frame_bad  = 1'b0;
    end
  end

  // Sequencer state registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= StIdle;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
    end
  end

  assign handshake = valid_q & i_ready;

  // Output holding register: load, consume, overrun and framing-error pulse.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    ferr_d  = frame_bad;

    if (handshake) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end

    if (frame_good) begin
      // A slot being consumed this very cycle is free for the new frame.
      if (!valid_q || i_ready) begin
        data_d  = shreg_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  // Output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_frame_err = ferr_q;
  assign o_overrun   = ovr_q;
  assign o_busy      = (state_q != StIdle);
  assign o_presc_en  = o_busy;

endmodule
